div_unit: RTL and testbench

Multi-cycle 32-bit integer divider implementing RV32M DIV, DIVU, REM and REMU by radix-2 restoring division, one quotient bit per clock, built on repeated trial subtraction. It sits beside the ALU in the execute stage. The core stalls on `o_ready` low and captures `o_data` on the `o_valid` pulse.

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_if.sv | 30 +++
 rtl/div_sub.sv | 18 +
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle RV32M divider.
//   WIDTH_C     : operand/result width (only 32 is supported)
//   CNT_W       : iteration counter width
//   div_op_e    : operation encoding as seen on i_op
//   div_state_e : controller states
// Optional feature macro used by div_unit: DIV_ZERO_FAST_EN.
package div_pkg;

    localparam int WIDTH_C = 32;
    localparam int CNT_W   = 6;

    // Bit 0 set means unsigned, bit 1 set means remainder.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Two's-complement magnitude of a value when it is to be treated as negative.
    function automatic logic [WIDTH_C-1:0] abs_if(input logic neg, input logic [WIDTH_C-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the execute stage and the divider.
//   i_start  : request, honoured only while o_ready is high
//   i_op     : operation (div_op_e encoding)
//   i_data_a : dividend
//   i_data_b : divisor
//   o_ready  : divider idle and able to accept a request
//   o_valid  : one-cycle pulse, new result on o_data
//   o_data   : quotient or remainder, held until the next result
// master modport = requester (core), slave modport = divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_data_a;
    logic [WIDTH-1:0] i_data_b;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;

    modport master (
        output i_start, i_op, i_data_a, i_data_b,
        input  o_ready, o_valid, o_data
    );

    modport slave (
        input  i_start, i_op, i_data_a, i_data_b,
        output o_ready, o_valid, o_data
    );
endinterface

// File: rtl/div_sub.sv
// Combinational trial subtractor used by one restoring-division iteration.
//   minuend    : shifted partial remainder
//   subtrahend : divisor magnitude (zero-extended)
//   diff       : minuend - subtrahend (low W bits)
//   borrow     : 1 when subtrahend > minuend, i.e. the trial failed
module div_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // One extra bit on each operand turns the carry-out into a borrow flag.
    assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring,
// one quotient bit per clock.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : div_if.slave (i_start/i_op/i_data_a/i_data_b in,
//           o_ready/o_valid/o_data out)
// Timing: accept at e0, iterations on e1..e32, result registered on e33;
// o_valid and o_ready are both high in the following cycle so a new request
// can be issued back-to-back.
// Optional feature: define DIV_ZERO_FAST_EN to bypass the iterations when
// the divisor is zero (result after one cycle, same values).
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
) (
    input  logic i_clk,
    input  logic i_rst,
    div_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_CALC = 2'(ST_CALC);
    localparam logic [1:0] S_FIX  = 2'(ST_FIX);

`ifdef DIV_ZERO_FAST_EN
    localparam bit ZERO_FAST = 1'b1;
`else
    localparam bit ZERO_FAST = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Controller and datapath state
    logic [1:0]       state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [WIDTH-1:0] rem_reg,     rem_next;
    // Holds the dividend magnitude at start; quotient bits shift in from the
    // right as dividend bits leave on the left.
    logic [WIDTH-1:0] quot_reg,    quot_next;
    logic [WIDTH-1:0] divisor_reg;
    logic             quot_neg_reg;
    logic             rem_neg_reg;
    logic             is_rem_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // Request decode
    logic             accept;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign accept    = (state_reg == S_IDLE) && bus.i_start;
    assign op_signed = ~bus.i_op[0];
    assign a_neg     = op_signed & bus.i_data_a[WIDTH-1];
    assign b_neg     = op_signed & bus.i_data_b[WIDTH-1];
    assign b_zero    = (bus.i_data_b == '0);
    assign mag_a     = abs_if(a_neg, bus.i_data_a);
    assign mag_b     = abs_if(b_neg, bus.i_data_b);

    // One iteration: shift next dividend bit into the partial remainder and
    // try to subtract the divisor.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] rem_step;

    assign shifted = {rem_reg, quot_reg[WIDTH-1]};

    div_sub #(
        .W (WIDTH + 1)
    ) u_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, divisor_reg}),
        .diff       (trial_diff),
        .borrow     (trial_borrow)
    );

    // The restored remainder is always below the divisor, so it fits in
    // WIDTH bits; the top difference bit carries no information.
    assign rem_step = trial_borrow ? shifted[WIDTH-1:0] : trial_diff[WIDTH-1:0];

    logic unused_diff_msb;
    assign unused_diff_msb = trial_diff[WIDTH];

    // Sign correction applied in FIX
    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;

    assign quot_fixed = abs_if(quot_neg_reg, quot_reg);
    assign rem_fixed  = abs_if(rem_neg_reg, rem_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rem_next   = rem_reg;
        quot_next  = quot_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_next = S_CALC;
                    cnt_next   = '0;
                    rem_next   = '0;
                    quot_next  = mag_a;
                    // A zero divisor always yields all-ones quotient and the
                    // dividend as remainder, so those can be loaded directly.
                    if (ZERO_FAST && b_zero) begin
                        state_next = S_FIX;
                        rem_next   = mag_a;
                        quot_next  = '1;
                    end
                end
            end
            S_CALC: begin
                rem_next  = rem_step;
                quot_next = {quot_reg[WIDTH-2:0], ~trial_borrow};
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ITER) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            divisor_reg  <= '0;
            quot_neg_reg <= 1'b0;
            rem_neg_reg  <= 1'b0;
            is_rem_reg   <= 1'b0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rem_reg   <= rem_next;
            quot_reg  <= quot_next;
            valid_reg <= 1'b0;
            if (accept) begin
                divisor_reg  <= mag_b;
                // Quotient negation is suppressed for a zero divisor so the
                // all-ones result survives for signed DIV as well.
                quot_neg_reg <= (a_neg ^ b_neg) & ~b_zero;
                rem_neg_reg  <= a_neg;
                is_rem_reg   <= bus.i_op[1];
            end
            if (state_reg == S_FIX) begin
                data_reg  <= is_rem_reg ? rem_fixed : quot_fixed;
                valid_reg <= 1'b1;
            end
        end
    end

    assign bus.o_ready = (state_reg == S_IDLE);
    assign bus.o_valid = valid_reg;
    assign bus.o_data  = data_reg;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    import div_pkg::*;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic clk;
    logic rst;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_count = 0;
    int err_count = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_count++;
        if (act !== req) begin
            err_count++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Waits (bounded) for o_valid, sampling 1 time unit after each edge.
    task automatic wait_result(output logic [31:0] res, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.o_valid) seen = 1'b1;
        end
        if (!seen) lat = 999;
        res = bus.o_data;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.i_op     = op;
        bus.i_data_a = a;
        bus.i_data_b = b;
        bus.i_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start  = 1'b0;
    endtask

    logic [31:0] res;
    int          lat;
    bit          stale;

    initial begin
        vec[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14,         33};
        vec[1]  = '{OP_REMU, 32'd100,        32'd7,        32'd2,          33};
        vec[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  33};
        vec[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  33};
        vec[4]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vec[5]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vec[6]  = '{OP_DIV,  32'h1234_5678,  32'd0,        32'hFFFF_FFFF,  ZLAT};
        vec[7]  = '{OP_DIVU, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF,  ZLAT};
        vec[8]  = '{OP_REM,  32'h1234_5678,  32'd0,        32'h1234_5678,  ZLAT};
        vec[9]  = '{OP_REMU, 32'h1234_5678,  32'd0,        32'h1234_5678,  ZLAT};
        vec[10] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vec[11] = '{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vec[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  33};
        vec[13] = '{OP_REM,  32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFF0,  ZLAT};

        bus.i_start  = 1'b0;
        bus.i_op     = 2'b00;
        bus.i_data_a = '0;
        bus.i_data_b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.o_ready), 32'd1);
        check("reset_valid", 32'(bus.o_valid), 32'd0);
        check("reset_data",  bus.o_data,       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            issue(vec[i].op, vec[i].a, vec[i].b);
            wait_result(res, lat);
            $display("vec %0d op=%0d a=0x%08h b=0x%08h -> 0x%08h lat=%0d",
                     i, vec[i].op, vec[i].a, vec[i].b, res, lat);
            check($sformatf("vec%0d_data", i), res, vec[i].exp_data);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vec[i].exp_lat));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse", i), 32'(bus.o_valid), 32'd0);
        end

        // Back-to-back issue with garbage on the inputs while busy
        issue(OP_DIVU, 32'd100, 32'd7);
        lat = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.o_valid) break;
            bus.i_start  = 1'($urandom_range(0, 1));
            bus.i_op     = 2'($urandom_range(0, 3));
            bus.i_data_a = $urandom;
            bus.i_data_b = $urandom;
        end
        $display("b2b first -> 0x%08h lat=%0d ready=%0d", bus.o_data, lat, bus.o_ready);
        check("b2b1_data",  bus.o_data,        32'd14);
        check("b2b1_lat",   32'(lat),          32'd33);
        check("b2b1_ready", 32'(bus.o_ready),  32'd1);
        bus.i_op     = OP_REM;
        bus.i_data_a = 32'hFFFF_FFF9;
        bus.i_data_b = 32'd2;
        bus.i_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start  = 1'b0;
        check("b2b_accept", 32'(bus.o_ready), 32'd0);
        wait_result(res, lat);
        $display("b2b second -> 0x%08h lat=%0d", res, lat);
        check("b2b2_data", res,      32'hFFFF_FFFF);
        check("b2b2_lat",  32'(lat), 32'd33);

        // Reset in the middle of an iteration run
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("mid-run reset ready=%0d valid=%0d data=0x%08h", bus.o_ready, bus.o_valid, bus.o_data);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data",  bus.o_data,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) stale = 1'b1;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_result(res, lat);
        $display("after reset DIVU 9/3 -> 0x%08h lat=%0d", res, lat);
        check("rst_new_data", res,      32'd3);
        check("rst_new_lat",  32'(lat), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
